// File: rtl/robot_pkg.sv
// Shared robot constants: ranging FSM states, sample error codes and the
// ultrasonic time-of-flight constant used by the scanner and motor_controller.
package robot_pkg;

    localparam int US_PER_CM = 58;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_NO_ECHO  = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_OVERLONG = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_SETTLE
    } scan_state_t;

endpackage

// File: rtl/us_prescaler.sv
// Free-running divider producing a one-cycle us_tick every CLK_HZ/1e6 clocks.
module us_prescaler #(
    parameter int CLK_HZ = 125_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic us_tick
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign us_tick = (cnt_q == LAST);

endmodule

// File: rtl/hc_sr04_scanner.sv
// Round-robin HC-SR04 ranging engine: triggers each masked sensor in turn,
// times its echo in whole cm and keeps the last in-range distance per channel.
module hc_sr04_scanner
    import robot_pkg::*;
#(
    parameter int N_SENSORS     = 3,
    parameter int CLK_HZ        = 125_000_000,
    parameter int DIST_W        = 16,
    parameter int TRIG_US       = 10,
    parameter int ECHO_START_US = 1000,
    parameter int ECHO_MAX_US   = 23200,
    parameter int SETTLE_US     = 20000,
    parameter int MIN_CM        = 2,
    parameter int MAX_CM        = 400,
    parameter int DEFAULT_CM    = 25,
    localparam int SEL_W        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                        clk_125mhz,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [N_SENSORS-1:0]        ch_mask,
    input  logic [N_SENSORS-1:0]        echo,
    output logic [N_SENSORS-1:0]        trig,
    output logic [N_SENSORS*DIST_W-1:0] distance,
    output logic [N_SENSORS-1:0]        valid,
    output logic                        sample_ready,
    output logic [SEL_W-1:0]            sample_ch,
    output logic [1:0]                  sample_err,
    output logic [2:0]                  fsm_state
);

    localparam int M1     = (TRIG_US > ECHO_START_US) ? TRIG_US : ECHO_START_US;
    localparam int M2     = (ECHO_MAX_US > SETTLE_US) ? ECHO_MAX_US : SETTLE_US;
    localparam int CNT_W  = $clog2(((M1 > M2) ? M1 : M2) + 1);
    localparam logic [CNT_W-1:0]  TRIG_LAST   = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0]  START_LAST  = CNT_W'(ECHO_START_US - 1);
    localparam logic [CNT_W-1:0]  MAX_LAST    = CNT_W'(ECHO_MAX_US - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_US - 1);
    localparam logic [5:0]        SUB_LAST    = 6'(US_PER_CM - 1);
    localparam logic [DIST_W-1:0] MIN_V       = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] MAX_V       = DIST_W'(MAX_CM);
    localparam logic [DIST_W-1:0] DEF_V       = DIST_W'(DEFAULT_CM);
    localparam logic [DIST_W-1:0] CM_SAT      = {DIST_W{1'b1}};

    scan_state_t         state_q, state_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]    us_q, us_d;
    logic [5:0]          sub_q, sub_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic [DIST_W-1:0]   dist_q [N_SENSORS];
    logic [N_SENSORS-1:0] echo_s, echo_prev, trig_d;
    logic [1:0]          err_d;
    logic                done, accept, us_tick, echo_rise, echo_fall;

    us_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk     (clk_125mhz),
        .reset_n (reset_n),
        .us_tick (us_tick)
    );

    for (genvar k = 0; k < N_SENSORS; k++) begin : g_sync
        logic s1, s2;
        always_ff @(posedge clk_125mhz or negedge reset_n) begin
            if (!reset_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= echo[k];
                s2 <= s1;
            end
        end
        assign echo_s[k] = s2;
        assign distance[k*DIST_W +: DIST_W] = dist_q[k];
    end

    // First masked channel strictly after 'last', wrapping; last itself comes last.
    function automatic logic [SEL_W-1:0] next_channel(input logic [SEL_W-1:0] last,
                                                      input logic [N_SENSORS-1:0] mask);
        logic [SEL_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_SENSORS; i++) begin
            idx = (int'(last) + i) % N_SENSORS;
            if (!found && mask[SEL_W'(idx)]) begin
                pick  = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign echo_rise = echo_s[ch_q] & ~echo_prev[ch_q];
    assign echo_fall = ~echo_s[ch_q] & echo_prev[ch_q];
    assign fsm_state = state_q;

    // sample_ready is a one-cycle strobe; sample_ch/sample_err are valid with it and
    // hold until the next strobe. There is no back-pressure.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        us_d    = us_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        done    = 1'b0;
        accept  = 1'b0;
        err_d   = ERR_OK;
        trig_d  = '0;
        case (state_q)
            ST_IDLE: begin
                // Starting on a tick aligns the trigger with whole prescaler periods.
                if (enable && (|ch_mask) && us_tick) begin
                    ch_d    = next_channel(ch_q, ch_mask);
                    us_d    = '0;
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (us_tick) begin
                    if (us_q == TRIG_LAST) begin
                        us_d    = '0;
                        state_d = ST_WAIT_ECHO;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_rise) begin
                    us_d    = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                    state_d = ST_MEASURE;
                end else if (us_tick) begin
                    if (us_q == START_LAST) begin
                        us_d    = '0;
                        done    = 1'b1;
                        err_d   = ERR_NO_ECHO;
                        state_d = ST_SETTLE;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            ST_MEASURE: begin
                if (us_tick) begin
                    us_d = us_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cm_q != CM_SAT) cm_d = cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                // cm_d already includes a tick landing in the fall cycle.
                if (echo_fall) begin
                    us_d    = '0;
                    done    = 1'b1;
                    state_d = ST_SETTLE;
                    if (cm_d >= MIN_V && cm_d <= MAX_V) begin
                        accept = 1'b1;
                        err_d  = ERR_OK;
                    end else begin
                        err_d  = ERR_RANGE;
                    end
                end else if (us_tick && us_q == MAX_LAST) begin
                    us_d    = '0;
                    done    = 1'b1;
                    err_d   = ERR_OVERLONG;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (us_tick) begin
                    if (us_q == SETTLE_LAST) begin
                        us_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_TRIG) trig_d[ch_d] = 1'b1;
    end

    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= SEL_W'(N_SENSORS - 1);
            us_q         <= '0;
            sub_q        <= '0;
            cm_q         <= '0;
            echo_prev    <= '0;
            trig         <= '0;
            valid        <= '0;
            sample_ready <= 1'b0;
            sample_ch    <= '0;
            sample_err   <= ERR_OK;
            for (int k = 0; k < N_SENSORS; k++) dist_q[k] <= DEF_V;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            us_q         <= us_d;
            sub_q        <= sub_d;
            cm_q         <= cm_d;
            echo_prev    <= echo_s;
            trig         <= trig_d;
            sample_ready <= done;
            if (done) begin
                sample_ch  <= ch_q;
                sample_err <= err_d;
            end
            if (accept) begin
                dist_q[ch_q] <= cm_d;
                valid[ch_q]  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hc_sr04_scanner.sv
// Directed bench for hc_sr04_scanner: the bench plays the sensors, predicts each
// attempt's result from the echo width and checks all outputs every cycle.
`timescale 1ns/1ps
module tb_hc_sr04_scanner;

    localparam int N           = 3;
    localparam int CLKS_PER_US = 4;
    localparam int TRIG_CLKS   = 40;
    localparam int ECHO_MAX    = 1500;
    localparam int MIN_CM      = 2;
    localparam int MAX_CM      = 20;
    localparam int DEF_CM      = 25;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  ch_mask = '0;
    logic [N-1:0]  echo = '0;
    logic [N-1:0]  trig;
    logic [N*16-1:0] distance;
    logic [N-1:0]  valid;
    logic          sample_ready;
    logic [1:0]    sample_ch;
    logic [1:0]    sample_err;
    logic [2:0]    fsm_state;

    int            n_checks = 0;
    int            n_fail = 0;
    int            model_dist [N];
    logic [N-1:0]  model_valid;
    logic [26:0]   exp_q [$];
    logic [26:0]   e;

    // clock / reset
    always #5 clk = ~clk;

    hc_sr04_scanner #(
        .N_SENSORS(3), .CLK_HZ(4_000_000), .DIST_W(16), .TRIG_US(10),
        .ECHO_START_US(1000), .ECHO_MAX_US(ECHO_MAX), .SETTLE_US(100),
        .MIN_CM(MIN_CM), .MAX_CM(MAX_CM), .DEFAULT_CM(DEF_CM)
    ) dut (
        .clk_125mhz(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
        .echo(echo), .trig(trig), .distance(distance), .valid(valid),
        .sample_ready(sample_ready), .sample_ch(sample_ch), .sample_err(sample_err),
        .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Expected result entry: {ch[7:0], err[1:0], accept, cm[15:0]}
    function automatic logic [26:0] model_entry(input int ch, input int width_us);
        int         cm;
        logic [1:0] err;
        logic       acc;
        cm  = 0;
        acc = 1'b0;
        if (width_us <= 0) err = 2'd1;
        else if (width_us >= ECHO_MAX) err = 2'd3;
        else begin
            cm = width_us / 58;
            if (cm >= MIN_CM && cm <= MAX_CM) begin
                err = 2'd0;
                acc = 1'b1;
            end else begin
                err = 2'd2;
            end
        end
        return {8'(ch), err, acc, 16'(cm)};
    endfunction

    function automatic logic [N*16-1:0] model_bus();
        logic [N*16-1:0] b;
        for (int k = 0; k < N; k++) b[k*16 +: 16] = 16'(model_dist[k]);
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) model_dist[k] = DEF_CM;
        model_valid = '0;
        exp_q.delete();
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sample_unexpected: actual ch%0d err%0d required no sample",
                             sample_ch, sample_err);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_ch", 64'(sample_ch), 64'(e[26:19]));
                    check("sample_err", 64'(sample_err), 64'(e[18:17]));
                    if (e[16]) begin
                        model_dist[e[26:19]] = int'(e[15:0]);
                        model_valid[e[26:19]] = 1'b1;
                    end
                end
            end
            check("distance", 64'(distance), 64'(model_bus()));
            check("valid", 64'(valid), 64'(model_valid));
            check("trig_onehot0", 64'($onehot0(trig)), 64'd1);
        end
    end

    // drivers
    task automatic trig_start(input int ch);
        int n;
        n = 0;
        while (trig == '0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (trig == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL trig_timeout: actual none required ch%0d", ch);
        end else begin
            check("trig_channel", 64'(trig), 64'd1 << ch);
        end
    endtask

    task automatic trig_measure(output int w);
        w = 1;
        @(negedge clk);
        while (trig != '0 && w < 1000) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sample_timeout: actual %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // width_us <= 0 means the sensor never answers
    task automatic shot(input int ch, input int width_us);
        int w;
        trig_start(ch);
        trig_measure(w);
        check("trig_width", 64'(w), 64'(TRIG_CLKS));
        exp_q.push_back(model_entry(ch, width_us));
        if (width_us > 0) begin
            repeat (20 * CLKS_PER_US) @(negedge clk);
            echo[ch] = 1'b1;
            repeat (width_us * CLKS_PER_US) @(negedge clk);
            echo[ch] = 1'b0;
        end
        wait_drain(20000);
    endtask

    initial begin
        int seen;
        model_reset();
        enable  = 1'b1;
        ch_mask = 3'b111;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_distance", 64'(distance), 64'(48'h0019_0019_0019));
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_trig", 64'(trig), 64'd0);
        check("rst_sample_ready", 64'(sample_ready), 64'd0);
        check("rst_sample_ch", 64'(sample_ch), 64'd0);
        check("rst_sample_err", 64'(sample_err), 64'd0);

        shot(0, 580);
        check("d0_580us", 64'(distance[15:0]), 64'd10);
        check("valid_ch0", 64'(valid), 64'd1);
        check("err_ch0_ok", 64'(sample_err), 64'd0);
        check("ch_ch0", 64'(sample_ch), 64'd0);
        shot(1, 58);
        check("d1_1cm_held", 64'(distance[31:16]), 64'd25);
        check("valid1_1cm", 64'(valid[1]), 64'd0);
        check("err_1cm", 64'(sample_err), 64'd2);
        shot(2, 0);
        check("err_no_echo", 64'(sample_err), 64'd1);
        check("ch_no_echo", 64'(sample_ch), 64'd2);
        shot(0, 116);
        check("d0_min_2cm", 64'(distance[15:0]), 64'd2);
        shot(1, 1560);
        check("err_overlong", 64'(sample_err), 64'd3);
        shot(2, 1160);
        check("d2_max_20cm", 64'(distance[47:32]), 64'd20);
        shot(0, 1218);
        check("err_21cm", 64'(sample_err), 64'd2);
        check("d0_21cm_held", 64'(distance[15:0]), 64'd2);
        shot(1, 300);
        check("d1_5cm", 64'(distance[31:16]), 64'd5);
        check("valid_all", 64'(valid), 64'd7);
        shot(2, 200);
        check("d2_3cm", 64'(distance[47:32]), 64'd3);

        ch_mask = 3'b101;
        shot(0, 400);
        shot(2, 600);
        shot(0, 100);
        shot(2, 1000);
        check("d0_mask101", 64'(distance[15:0]), 64'd6);
        check("d2_mask101", 64'(distance[47:32]), 64'd17);

        ch_mask = 3'b000;
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (trig != '0) seen++;
        end
        check("mask0_no_trig", 64'(seen), 64'd0);

        ch_mask = 3'b111;
        shot(0, 580);

        // asynchronous reset in the middle of a ch1 measurement
        trig_start(1);
        trig_measure(seen);
        repeat (20 * CLKS_PER_US) @(negedge clk);
        echo[1] = 1'b1;
        repeat (800) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_meas_trig", 64'(trig), 64'd0);
        check("rst_meas_distance", 64'(distance), 64'(48'h0019_0019_0019));
        check("rst_meas_valid", 64'(valid), 64'd0);
        check("rst_meas_ready", 64'(sample_ready), 64'd0);
        echo = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // asynchronous reset while the trigger is high
        trig_start(0);
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_trig_drop", 64'(trig), 64'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        shot(0, 580);
        check("d0_after_reset", 64'(distance[15:0]), 64'd10);
        check("valid_after_reset", 64'(valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
